// File: rtl/ex_mem_pipe_stage.sv
// ex_mem_pipe_stage
//   EX->MEM pipeline register with a valid/ready handshake on both sides and a
//   two-entry skid buffer (MAIN drives the outputs, SKID catches the entry that
//   arrives in the cycle downstream stalls). in_ready is registered, so the
//   upstream ready path never depends combinationally on out_ready.
//   A synchronous flush empties the stage. stall_cnt counts cycles where an
//   entry is presented but not taken, and saturates at its maximum value.
// Ports
//   clk, reset_in (async, active-low), flush_in (sync)
//   upstream  : in_valid, in_ready, RegWrite_in, MemtoReg_in, MemRead_in,
//               MemWrite_in, ALU_Result_in, RT_data_in, WriteReg_in
//   downstream: out_valid, out_ready, RegWrite_out, MemtoReg_out, MemRead_out,
//               MemWrite_out, ALU_Result_out, RT_data_out, WriteReg_out
//   status    : stall_cnt
module ex_mem_pipe_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_in,
    input  logic              flush_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              RegWrite_in,
    input  logic              MemtoReg_in,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic [DATA_W-1:0] ALU_Result_in,
    input  logic [DATA_W-1:0] RT_data_in,
    input  logic [REG_AW-1:0] WriteReg_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              RegWrite_out,
    output logic              MemtoReg_out,
    output logic              MemRead_out,
    output logic              MemWrite_out,
    output logic [DATA_W-1:0] ALU_Result_out,
    output logic [DATA_W-1:0] RT_data_out,
    output logic [REG_AW-1:0] WriteReg_out,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_n;

    // Control bits packed as {RegWrite, MemtoReg, MemRead, MemWrite}
    logic [3:0]        main_ctrl, main_ctrl_n, skid_ctrl, skid_ctrl_n;
    logic [DATA_W-1:0] main_alu,  main_alu_n,  skid_alu,  skid_alu_n;
    logic [DATA_W-1:0] main_rt,   main_rt_n,   skid_rt,   skid_rt_n;
    logic [REG_AW-1:0] main_wr,   main_wr_n,   skid_wr,   skid_wr_n;
    logic              in_ready_n;
    logic              acc, drn;
    logic [3:0]        in_ctrl;

    always_comb begin
        out_valid = (state != EMPTY);
        in_ctrl   = {RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in};
        acc       = in_valid & in_ready;
        drn       = out_valid & out_ready;
    end

    always_comb begin
        state_n     = state;
        main_ctrl_n = main_ctrl;
        main_alu_n  = main_alu;
        main_rt_n   = main_rt;
        main_wr_n   = main_wr;
        skid_ctrl_n = skid_ctrl;
        skid_alu_n  = skid_alu;
        skid_rt_n   = skid_rt;
        skid_wr_n   = skid_wr;

        case (state)
            EMPTY: begin
                if (acc) begin
                    main_ctrl_n = in_ctrl;
                    main_alu_n  = ALU_Result_in;
                    main_rt_n   = RT_data_in;
                    main_wr_n   = WriteReg_in;
                    state_n     = ONE;
                end
            end
            ONE: begin
                if (acc && drn) begin
                    main_ctrl_n = in_ctrl;
                    main_alu_n  = ALU_Result_in;
                    main_rt_n   = RT_data_in;
                    main_wr_n   = WriteReg_in;
                end else if (acc) begin
                    skid_ctrl_n = in_ctrl;
                    skid_alu_n  = ALU_Result_in;
                    skid_rt_n   = RT_data_in;
                    skid_wr_n   = WriteReg_in;
                    state_n     = FULL;
                end else if (drn) begin
                    // Clearing control here keeps bubbles harmless downstream
                    main_ctrl_n = '0;
                    state_n     = EMPTY;
                end
            end
            FULL: begin
                if (drn) begin
                    main_ctrl_n = skid_ctrl;
                    main_alu_n  = skid_alu;
                    main_rt_n   = skid_rt;
                    main_wr_n   = skid_wr;
                    skid_ctrl_n = '0;
                    state_n     = ONE;
                end
            end
            default: begin
                main_ctrl_n = '0;
                skid_ctrl_n = '0;
                state_n     = EMPTY;
            end
        endcase

        // Flush wins: payload registers keep their pre-flush contents so a
        // discarded same-cycle input never shows up on the held outputs.
        if (flush_in) begin
            state_n     = EMPTY;
            main_ctrl_n = '0;
            skid_ctrl_n = '0;
            main_alu_n  = main_alu;
            main_rt_n   = main_rt;
            main_wr_n   = main_wr;
            skid_alu_n  = skid_alu;
            skid_rt_n   = skid_rt;
            skid_wr_n   = skid_wr;
        end

        in_ready_n = (state_n != FULL);
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            main_ctrl <= '0;
            main_alu  <= '0;
            main_rt   <= '0;
            main_wr   <= '0;
            skid_ctrl <= '0;
            skid_alu  <= '0;
            skid_rt   <= '0;
            skid_wr   <= '0;
        end else begin
            state     <= state_n;
            in_ready  <= in_ready_n;
            main_ctrl <= main_ctrl_n;
            main_alu  <= main_alu_n;
            main_rt   <= main_rt_n;
            main_wr   <= main_wr_n;
            skid_ctrl <= skid_ctrl_n;
            skid_alu  <= skid_alu_n;
            skid_rt   <= skid_rt_n;
            skid_wr   <= skid_wr_n;
        end
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    always_comb begin
        {RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out} = main_ctrl;
        ALU_Result_out = main_alu;
        RT_data_out    = main_rt;
        WriteReg_out   = main_wr;
    end

endmodule
